// File: rtl/stream_rr_arbiter_if.sv
// ============================================================================
// Module   : stream_rr_arbiter_if
// Brief    : Handshake bundle between NUM_PORTS requesters, the arbiter and
//            the single downstream consumer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface stream_rr_arbiter_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int SRC_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  logic [NUM_PORTS-1:0]            in_valid;
  logic [NUM_PORTS-1:0]            in_ready;
  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_PORTS-1:0]            in_last;
  logic                            o_valid;
  logic                            o_ready;
  logic [DATA_WIDTH-1:0]           o_data;
  logic                            o_last;
  logic [SRC_BITS-1:0]             o_src;
  logic                            busy;

  // Arbiter side
  modport slave (
    input  in_valid, in_data, in_last, o_ready,
    output in_ready, o_valid, o_data, o_last, o_src, busy
  );

  // Requesters plus downstream consumer side
  modport master (
    output in_valid, in_data, in_last, o_ready,
    input  in_ready, o_valid, o_data, o_last, o_src, busy
  );
endinterface

`default_nettype wire

// File: rtl/stream_rr_arbiter.sv
// ============================================================================
// Module   : stream_rr_arbiter
// Brief    : Round-robin, packet-locked arbiter merging NUM_PORTS valid/ready
//            streams into one registered, source-tagged output stream.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_rr_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  wire logic             clk,
  input  wire logic             reset_n,
  stream_rr_arbiter_if.slave    bus
);

  localparam int SRC_BITS = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  state_t                state_q,   state_d;
  logic [SRC_BITS-1:0]   ptr_q,     ptr_d;
  logic [SRC_BITS-1:0]   g_q,       g_d;
  logic [NUM_PORTS-1:0]  gnt_q,     gnt_d;
  logic                  o_valid_q, o_valid_d;
  logic [DATA_WIDTH-1:0] o_data_q,  o_data_d;
  logic                  o_last_q,  o_last_d;
  logic [SRC_BITS-1:0]   o_src_q,   o_src_d;
  logic                  busy_q,    busy_d;

  logic                  out_free;
  logic                  accept;
  logic                  win_found;
  logic [SRC_BITS-1:0]   win_idx;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_last;

  // gnt_q is a registered one-hot of g (all zero in IDLE), so in_ready is a
  // single AND level away from the output register state.
  assign out_free     = !o_valid_q || bus.o_ready;
  assign bus.in_ready = gnt_q & {NUM_PORTS{out_free}};
  assign accept       = |(bus.in_valid & bus.in_ready);

  assign bus.o_valid  = o_valid_q;
  assign bus.o_data   = o_data_q;
  assign bus.o_last   = o_last_q;
  assign bus.o_src    = o_src_q;
  assign bus.busy     = busy_q;

  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (g_q == SRC_BITS'(k)) begin
        sel_data = bus.in_data[k*DATA_WIDTH +: DATA_WIDTH];
        sel_last = bus.in_last[k];
      end
    end
  end

  // First valid requester scanning upward from ptr, wrapping at NUM_PORTS.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= NUM_PORTS) begin
        idx = idx - NUM_PORTS;
      end
      for (int k = 0; k < NUM_PORTS; k++) begin
        if (!win_found && (k == idx) && bus.in_valid[k]) begin
          win_found = 1'b1;
          win_idx   = SRC_BITS'(k);
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    g_d       = g_q;
    gnt_d     = gnt_q;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_last_d  = o_last_q;
    o_src_d   = o_src_q;

    if (o_valid_q && bus.o_ready) begin
      o_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d = LOCKED;
          g_d     = win_idx;
          for (int k = 0; k < NUM_PORTS; k++) begin
            gnt_d[k] = (win_idx == SRC_BITS'(k));
          end
        end
      end
      LOCKED: begin
        if (accept) begin
          o_valid_d = 1'b1;
          o_data_d  = sel_data;
          o_last_d  = sel_last;
          o_src_d   = g_q;
          if (sel_last) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = (g_q == SRC_BITS'(NUM_PORTS - 1)) ? '0 : g_q + SRC_BITS'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    busy_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      g_q       <= '0;
      gnt_q     <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_last_q  <= 1'b0;
      o_src_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      g_q       <= g_d;
      gnt_q     <= gnt_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_last_q  <= o_last_d;
      o_src_q   <= o_src_d;
      busy_q    <= busy_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_rr_arbiter.sv
// ============================================================================
// Module   : tb_stream_rr_arbiter
// Brief    : Directed self-checking bench for stream_rr_arbiter (4 ports, 8b).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_rr_arbiter;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;

  stream_rr_arbiter_if #(.NUM_PORTS(4), .DATA_WIDTH(8)) bus ();

  stream_rr_arbiter #(
    .NUM_PORTS  (4),
    .DATA_WIDTH (8)
  ) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Registered outputs are stable 2 time units after the rising edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_port(input int k, input logic [7:0] d, input logic l);
    bus.in_data[k*8 +: 8] = d;
    bus.in_last[k]        = l;
  endtask

  task automatic check_beat(input string tag, input logic [7:0] d, input logic l, input logic [1:0] s);
    check_eq({tag, ".valid"}, {31'd0, bus.o_valid}, 32'd1);
    check_eq({tag, ".data"},  {24'd0, bus.o_data},  {24'd0, d});
    check_eq({tag, ".last"},  {31'd0, bus.o_last},  {31'd0, l});
    check_eq({tag, ".src"},   {30'd0, bus.o_src},   {30'd0, s});
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    reset_n      = 1'b1;
    bus.in_valid = '0;
    bus.in_data  = '0;
    bus.in_last  = '0;
    bus.o_ready  = 1'b1;

    // Reset with every port requesting
    #1 reset_n = 1'b0;
    for (int k = 0; k < 4; k++) set_port(k, 8'hA0 + 8'(k), 1'b1);
    bus.in_valid = 4'b1111;
    repeat (3) tick();
    check_eq("rst.o_valid",  {31'd0, bus.o_valid},  32'd0);
    check_eq("rst.o_data",   {24'd0, bus.o_data},   32'd0);
    check_eq("rst.o_last",   {31'd0, bus.o_last},   32'd0);
    check_eq("rst.o_src",    {30'd0, bus.o_src},    32'd0);
    check_eq("rst.busy",     {31'd0, bus.busy},     32'd0);
    check_eq("rst.in_ready", {28'd0, bus.in_ready}, 32'd0);
    reset_n = 1'b1;
    tick();
    check_eq("rel.busy",     {31'd0, bus.busy},     32'd1);
    check_eq("rel.in_ready", {28'd0, bus.in_ready}, 32'd1);
    check_eq("rel.o_valid",  {31'd0, bus.o_valid},  32'd0);
    tick();
    check_beat("rel.beat", 8'hA0, 1'b1, 2'd0);
    check_eq("rel.busy_fall", {31'd0, bus.busy}, 32'd0);
    bus.in_valid = '0;
    tick();
    check_eq("rel.drain", {31'd0, bus.o_valid}, 32'd0);

    // Single requester, 3-beat packet on port 2 (ptr is 1)
    set_port(2, 8'h11, 1'b0);
    bus.in_valid = 4'b0100;
    tick();
    check_eq("p2.in_ready", {28'd0, bus.in_ready}, 32'h4);
    tick();
    check_beat("p2.b0", 8'h11, 1'b0, 2'd2);
    set_port(2, 8'h12, 1'b0);
    tick();
    check_beat("p2.b1", 8'h12, 1'b0, 2'd2);
    set_port(2, 8'h13, 1'b1);
    tick();
    check_beat("p2.b2", 8'h13, 1'b1, 2'd2);
    check_eq("p2.busy", {31'd0, bus.busy}, 32'd0);
    bus.in_valid = '0;
    tick();
    check_eq("p2.drain", {31'd0, bus.o_valid}, 32'd0);

    // Fairness: ptr is now 3, so order is 3,0,1,2,3 with a bubble each
    for (int k = 0; k < 4; k++) set_port(k, 8'hA0 + 8'(k), 1'b1);
    bus.in_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("rr.bubble", {31'd0, bus.o_valid}, 32'd0);
      tick();
      check_beat("rr.beat", 8'hA0 + 8'((3 + i) % 4), 1'b1, 2'((3 + i) % 4));
    end
    bus.in_valid = '0;
    tick();

    // Lock hold: port 1 stalls mid-packet while port 0 requests (ptr is 0)
    set_port(1, 8'h21, 1'b0);
    bus.in_valid = 4'b0010;
    tick();
    set_port(0, 8'hA0, 1'b1);
    bus.in_valid = 4'b0011;
    tick();
    check_beat("lock.b0", 8'h21, 1'b0, 2'd1);
    bus.in_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_eq("lock.o_valid",  {31'd0, bus.o_valid},  32'd0);
      check_eq("lock.busy",     {31'd0, bus.busy},     32'd1);
      check_eq("lock.in_ready", {28'd0, bus.in_ready}, 32'h2);
    end
    set_port(1, 8'h22, 1'b1);
    set_port(3, 8'hA3, 1'b1);
    bus.in_valid = 4'b1011;
    tick();
    check_beat("lock.b1", 8'h22, 1'b1, 2'd1);
    bus.in_valid = 4'b1001;
    tick();
    check_eq("lock.next_gnt", {28'd0, bus.in_ready}, 32'h8);
    tick();
    check_beat("lock.p3", 8'hA3, 1'b1, 2'd3);
    bus.in_valid = '0;
    tick();

    // Back-pressure mid-packet on port 0 (ptr is 0)
    set_port(0, 8'h31, 1'b0);
    bus.in_valid = 4'b0001;
    tick();
    tick();
    check_beat("bp.b0", 8'h31, 1'b0, 2'd0);
    set_port(0, 8'h32, 1'b0);
    bus.o_ready = 1'b0;
    #1;
    check_eq("bp.in_ready0", {28'd0, bus.in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_beat("bp.hold", 8'h31, 1'b0, 2'd0);
      check_eq("bp.in_ready", {28'd0, bus.in_ready}, 32'd0);
    end
    bus.o_ready = 1'b1;
    #1;
    check_eq("bp.resume_rdy", {28'd0, bus.in_ready}, 32'd1);
    tick();
    check_beat("bp.b1", 8'h32, 1'b0, 2'd0);
    set_port(0, 8'h33, 1'b0);
    tick();
    check_beat("bp.b2", 8'h33, 1'b0, 2'd0);
    set_port(0, 8'h34, 1'b1);
    tick();
    check_beat("bp.b3", 8'h34, 1'b1, 2'd0);
    bus.in_valid = '0;
    tick();
    check_eq("bp.drain", {31'd0, bus.o_valid}, 32'd0);

    // Asynchronous reset during beat 2 of 4 on port 1 (ptr is 1)
    set_port(1, 8'h41, 1'b0);
    bus.in_valid = 4'b0010;
    tick();
    tick();
    check_beat("ar.b0", 8'h41, 1'b0, 2'd1);
    set_port(1, 8'h42, 1'b0);
    tick();
    check_beat("ar.b1", 8'h42, 1'b0, 2'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("ar.o_valid",  {31'd0, bus.o_valid},  32'd0);
    check_eq("ar.busy",     {31'd0, bus.busy},     32'd0);
    check_eq("ar.in_ready", {28'd0, bus.in_ready}, 32'd0);
    tick();
    reset_n = 1'b1;
    set_port(1, 8'h43, 1'b0);
    set_port(0, 8'h50, 1'b1);
    bus.in_valid = 4'b0011;
    tick();
    check_eq("ar.gnt0", {28'd0, bus.in_ready}, 32'd1);
    tick();
    check_beat("ar.p0", 8'h50, 1'b1, 2'd0);
    bus.in_valid = '0;
    tick();
    check_eq("ar.drain", {31'd0, bus.o_valid}, 32'd0);
    check_eq("ar.idle",  {31'd0, bus.busy},    32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
